// File: rtl/wb_mem_arbiter.sv
// wb_mem_arbiter: arbitrates the instruction-fetch master (I) and the
// load/store master (D) onto one Wishbone-style memory slave port.
// Each access runs IDLE -> ISSUE -> RESP; the slave acks combinationally
// in its strobe cycle and its read data is valid in the following cycle.
//
// Build option: define WBARB_ROUND_ROBIN_EN to replace fixed D priority
// (with the starvation limit) by round-robin between I and D.
//
// state | meaning
// IDLE  | no access in flight, requests sampled and arbitrated here
// ISSUE | slave strobe driven from latched fields, waiting for s_ack_i
// RESP  | owner's ack pulse, read data routed from s_dat_i
module wb_mem_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] i_adr_i,
  input  logic          i_stb_i,
  output logic [DW-1:0] i_dat_o,
  output logic          i_ack_o,
  input  logic [AW-1:0] d_adr_i,
  input  logic [DW-1:0] d_dat_i,
  input  logic          d_we_i,
  input  logic          d_stb_i,
  output logic [DW-1:0] d_dat_o,
  output logic          d_ack_o,
  output logic [AW-1:0] s_adr_o,
  output logic [DW-1:0] s_dat_o,
  output logic          s_we_o,
  output logic          s_stb_o,
  input  logic [DW-1:0] s_dat_i,
  input  logic          s_ack_i
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_owner_i;
  logic [AW-1:0] r_adr;
  logic [DW-1:0] r_dat;
  logic          r_we;
  logic [DW-1:0] r_i_dat;
  logic [DW-1:0] r_d_dat;
  logic          w_req;
  logic          w_grant_i;
  logic          w_take;

  assign w_req  = i_stb_i | d_stb_i;
  assign w_take = (r_state == ST_IDLE) && w_req;

`ifdef WBARB_ROUND_ROBIN_EN
  logic r_last_i;

  // On contention the master that did not win last time gets the slot
  always_comb begin
    w_grant_i = i_stb_i;
    if (i_stb_i && d_stb_i) w_grant_i = ~r_last_i;
  end

  // Remember who won every grant, contended or not
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_last_i <= 1'b0;
    else if (w_take) r_last_i <= w_grant_i;
  end
`else
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  logic [3:0] r_starve;

  // D has priority unless I has waited through LIMIT consecutive D grants
  always_comb begin
    w_grant_i = i_stb_i && (!d_stb_i || (r_starve == LIMIT));
  end

  // Count D grants taken while I was waiting; any other grant clears it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve <= '0;
    end else if (w_take) begin
      if (w_grant_i || !i_stb_i) r_starve <= '0;
      else if (r_starve != LIMIT) r_starve <= r_starve + 4'd1;
    end
  end
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state and per-phase outputs
  always_comb begin
    w_state_nxt = r_state;
    s_stb_o     = 1'b0;
    s_we_o      = 1'b0;
    i_ack_o     = 1'b0;
    d_ack_o     = 1'b0;
    i_dat_o     = r_i_dat;
    d_dat_o     = r_d_dat;
    case (r_state)
      ST_IDLE: begin
        if (w_req) w_state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        s_stb_o = 1'b1;
        s_we_o  = r_we;
        if (s_ack_i) w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        if (r_owner_i) begin
          i_ack_o = 1'b1;
          if (!r_we) i_dat_o = s_dat_i;
        end else begin
          d_ack_o = 1'b1;
          if (!r_we) d_dat_o = s_dat_i;
        end
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign s_adr_o = r_adr;
  assign s_dat_o = r_dat;

  // Latch the winner's request so the slave sees stable fields through ISSUE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner_i <= 1'b0;
      r_adr     <= '0;
      r_dat     <= '0;
      r_we      <= 1'b0;
    end else if (w_take) begin
      r_owner_i <= w_grant_i;
      r_adr     <= w_grant_i ? i_adr_i : d_adr_i;
      r_dat     <= w_grant_i ? '0 : d_dat_i;
      r_we      <= ~w_grant_i & d_we_i;
    end
  end

  // Hold each master's last read data between its acks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_i_dat <= '0;
      r_d_dat <= '0;
    end else if ((r_state == ST_RESP) && !r_we) begin
      if (r_owner_i) r_i_dat <= s_dat_i;
      else           r_d_dat <= s_dat_i;
    end
  end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Bench for wb_mem_arbiter: a transaction-level reference model checked on
// every negative clock edge, plus directed scenarios with literal values.
module tb_wb_mem_arbiter;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int LIMIT = 4;

  logic          clk;
  logic          rst;
  logic [AW-1:0] i_adr_i;
  logic          i_stb_i;
  logic [DW-1:0] i_dat_o;
  logic          i_ack_o;
  logic [AW-1:0] d_adr_i;
  logic [DW-1:0] d_dat_i;
  logic          d_we_i;
  logic          d_stb_i;
  logic [DW-1:0] d_dat_o;
  logic          d_ack_o;
  logic [AW-1:0] s_adr_o;
  logic [DW-1:0] s_dat_o;
  logic          s_we_o;
  logic          s_stb_o;
  logic [DW-1:0] s_dat_i = '0;
  logic          s_ack_i;
  logic          slv_ready;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  wb_mem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .i_adr_i(i_adr_i), .i_stb_i(i_stb_i), .i_dat_o(i_dat_o), .i_ack_o(i_ack_o),
    .d_adr_i(d_adr_i), .d_dat_i(d_dat_i), .d_we_i(d_we_i), .d_stb_i(d_stb_i),
    .d_dat_o(d_dat_o), .d_ack_o(d_ack_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_we_o(s_we_o), .s_stb_o(s_stb_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input int idx);
    return (idx == 4) ? 32'hDEAD_BEEF : 32'h1000_0000 + 32'(idx);
  endfunction

  // Slave: acks in the strobe cycle when ready, read data registered
  logic [31:0] s_mem [0:15];
  logic [15:0] s_vld = '0;
  assign s_ack_i = s_stb_o & slv_ready;

  always @(posedge clk) begin
    if (s_stb_o && s_ack_i) begin
      if (s_we_o) begin
        s_mem[s_adr_o[5:2]] <= s_dat_o;
        s_vld[s_adr_o[5:2]] <= 1'b1;
      end else begin
        s_dat_i <= s_vld[s_adr_o[5:2]] ? s_mem[s_adr_o[5:2]] : init_word(int'(s_adr_o[5:2]));
      end
    end
  end

  // Reference model: one outstanding transaction record, advanced per cycle
  logic [31:0] m_mem [0:15];
  bit          m_busy, m_done, m_is_i, m_we, m_last_i;
  logic [31:0] m_adr, m_dat, m_rdata, m_i_held, m_d_held;
  int          m_starve;

  initial begin
    bit exp_stb, exp_iack, exp_dack, pick_i;
    logic [31:0] exp_idat, exp_ddat;
    for (int k = 0; k < 16; k++) m_mem[k] = init_word(k);
    m_busy = 0; m_done = 0; m_is_i = 0; m_we = 0; m_last_i = 0; m_starve = 0;
    m_adr = '0; m_dat = '0; m_rdata = '0; m_i_held = '0; m_d_held = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("mdl_rst_s_stb", 32'(s_stb_o), 32'd0);
        chk("mdl_rst_s_we",  32'(s_we_o),  32'd0);
        chk("mdl_rst_s_adr", s_adr_o, 32'd0);
        chk("mdl_rst_s_dat", s_dat_o, 32'd0);
        chk("mdl_rst_i_ack", 32'(i_ack_o), 32'd0);
        chk("mdl_rst_d_ack", 32'(d_ack_o), 32'd0);
        chk("mdl_rst_i_dat", i_dat_o, 32'd0);
        chk("mdl_rst_d_dat", d_dat_o, 32'd0);
        m_busy = 0; m_done = 0; m_starve = 0; m_last_i = 0;
        m_i_held = '0; m_d_held = '0;
      end else begin
        exp_stb  = m_busy && !m_done;
        exp_iack = m_busy && m_done && m_is_i;
        exp_dack = m_busy && m_done && !m_is_i;
        exp_idat = (exp_iack && !m_we) ? m_rdata : m_i_held;
        exp_ddat = (exp_dack && !m_we) ? m_rdata : m_d_held;
        chk("mdl_s_stb", 32'(s_stb_o), 32'(exp_stb));
        chk("mdl_i_ack", 32'(i_ack_o), 32'(exp_iack));
        chk("mdl_d_ack", 32'(d_ack_o), 32'(exp_dack));
        chk("mdl_i_dat", i_dat_o, exp_idat);
        chk("mdl_d_dat", d_dat_o, exp_ddat);
        chk("mdl_ack_excl", 32'(i_ack_o & d_ack_o), 32'd0);
        if (exp_stb) begin
          chk("mdl_s_adr", s_adr_o, m_adr);
          chk("mdl_s_we", 32'(s_we_o), 32'(m_we));
          if (m_we) chk("mdl_s_dat", s_dat_o, m_dat);
        end
        // advance to next cycle
        if (m_busy && m_done) begin
          if (!m_we) begin
            if (m_is_i) m_i_held = m_rdata;
            else        m_d_held = m_rdata;
          end
          m_busy = 0;
        end else if (m_busy) begin
          if (slv_ready) begin
            m_done = 1;
            if (m_we) m_mem[m_adr[5:2]] = m_dat;
            else      m_rdata = m_mem[m_adr[5:2]];
          end
        end else if (i_stb_i || d_stb_i) begin
`ifdef WBARB_ROUND_ROBIN_EN
          if (i_stb_i && d_stb_i) pick_i = !m_last_i;
          else                    pick_i = i_stb_i;
          m_last_i = pick_i;
`else
          if (i_stb_i && m_starve >= LIMIT) pick_i = 1;
          else if (d_stb_i)                 pick_i = 0;
          else                              pick_i = 1;
          if (pick_i)       m_starve = 0;
          else if (i_stb_i) m_starve = (m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1;
          else              m_starve = 0;
`endif
          m_is_i = pick_i;
          m_adr  = pick_i ? i_adr_i : d_adr_i;
          m_we   = pick_i ? 1'b0 : d_we_i;
          m_dat  = d_dat_i;
          m_busy = 1;
          m_done = 0;
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Directed scenarios with hand-computed values
  initial begin
    byte  got_who [$];
    int   got_cyc [$];
    string exp_ord;
    rst = 1; slv_ready = 1;
    i_adr_i = '0; i_stb_i = 0; d_adr_i = '0; d_dat_i = '0; d_we_i = 0; d_stb_i = 0;
`ifdef WBARB_ROUND_ROBIN_EN
    exp_ord = "IDIDIDIDID";
`else
    exp_ord = "DDDDIDDDDI";
`endif
    wait_cyc(2);
    chk("rst_s_stb", 32'(s_stb_o), 32'd0);
    chk("rst_acks", 32'({i_ack_o, d_ack_o}), 32'd0);
    chk("rst_s_adr", s_adr_o, 32'd0);
    rst = 0;
    wait_cyc(2);

    // single I read
    i_adr_i = 32'h0000_0010; i_stb_i = 1;
    wait_cyc(1);
    chk("t1_s_stb", 32'(s_stb_o), 32'd1);
    chk("t1_s_adr", s_adr_o, 32'h10);
    chk("t1_s_we", 32'(s_we_o), 32'd0);
    chk("t1_i_ack_c1", 32'(i_ack_o), 32'd0);
    wait_cyc(1);
    chk("t1_i_ack_c2", 32'(i_ack_o), 32'd1);
    chk("t1_i_dat", i_dat_o, 32'hDEAD_BEEF);
    chk("t1_d_ack", 32'(d_ack_o), 32'd0);
    i_stb_i = 0;
    wait_cyc(1);
    chk("t1_i_ack_c3", 32'(i_ack_o), 32'd0);
    wait_cyc(1);

    // D write
    d_adr_i = 32'h20; d_dat_i = 32'h1234_5678; d_we_i = 1; d_stb_i = 1;
    wait_cyc(1);
    chk("t2_s_we", 32'(s_we_o), 32'd1);
    chk("t2_s_dat", s_dat_o, 32'h1234_5678);
    wait_cyc(1);
    chk("t2_d_ack", 32'(d_ack_o), 32'd1);
    chk("t2_i_ack", 32'(i_ack_o), 32'd0);
    d_stb_i = 0; d_we_i = 0;
    wait_cyc(1);
    chk("t2_d_ack_off", 32'(d_ack_o), 32'd0);
    wait_cyc(1);

    // wait state of two cycles, reading back the word just written
    slv_ready = 0; d_adr_i = 32'h20; d_stb_i = 1;
    for (int k = 1; k <= 3; k++) begin
      wait_cyc(1);
      chk("t3_s_stb", 32'(s_stb_o), 32'd1);
      chk("t3_s_adr", s_adr_o, 32'h20);
      chk("t3_d_ack_early", 32'(d_ack_o), 32'd0);
      if (k == 3) slv_ready = 1;
    end
    wait_cyc(1);
    chk("t3_d_ack", 32'(d_ack_o), 32'd1);
    chk("t3_d_dat", d_dat_o, 32'h1234_5678);
    d_stb_i = 0;
    wait_cyc(1);
    chk("t3_d_ack_off", 32'(d_ack_o), 32'd0);
    wait_cyc(1);

    // contention: both masters requesting continuously
    i_adr_i = 32'h10; d_adr_i = 32'h08; d_we_i = 0; i_stb_i = 1; d_stb_i = 1;
    for (int c = 0; c < 40 && got_who.size() < 10; c++) begin
      wait_cyc(1);
      if (i_ack_o) begin got_who.push_back("I"); got_cyc.push_back(cyc); end
      if (d_ack_o) begin got_who.push_back("D"); got_cyc.push_back(cyc); end
    end
    i_stb_i = 0; d_stb_i = 0;
    chk("t4_grant_count", 32'(got_who.size()), 32'd10);
    for (int k = 0; k < 10 && k < got_who.size(); k++)
      chk($sformatf("t4_grant_%0d", k), 32'(got_who[k]), 32'(exp_ord[k]));
    for (int k = 1; k < got_cyc.size(); k++)
      chk($sformatf("t4_gap_%0d", k), 32'(got_cyc[k] - got_cyc[k-1]), 32'd3);
    wait_cyc(4);

    // reset while the slave strobe is up
    d_adr_i = 32'h30; d_dat_i = 32'hCAFE_0001; d_we_i = 1; d_stb_i = 1;
    wait_cyc(1);
    chk("t5_s_stb_pre", 32'(s_stb_o), 32'd1);
    rst = 1;
    #1;
    chk("t5_s_stb_async", 32'(s_stb_o), 32'd0);
    chk("t5_d_ack_async", 32'(d_ack_o), 32'd0);
    d_stb_i = 0; d_we_i = 0;
    wait_cyc(2);
    chk("t5_acks_in_rst", 32'({i_ack_o, d_ack_o}), 32'd0);
    rst = 0;
    wait_cyc(1);
    d_adr_i = 32'h30; d_stb_i = 1;
    wait_cyc(1);
    chk("t5_s_stb", 32'(s_stb_o), 32'd1);
    wait_cyc(1);
    chk("t5_d_ack", 32'(d_ack_o), 32'd1);
    chk("t5_d_dat", d_dat_o, 32'h1000_000C);
    d_stb_i = 0;
    wait_cyc(1);
    chk("t5_d_ack_off", 32'(d_ack_o), 32'd0);
    wait_cyc(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
